// File: rtl/stack_sequencer.sv
// Micro-sequencer for PUSH rr / POP rr: drives register-file strobes and byte-wide stack accesses.
// Optional feature: define STACK_SEQ_PC_EN to accept i_Pair=4 (PC).
module stack_sequencer (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Enable,
  input  logic        i_Start,
  input  logic        i_Op,
  input  logic [2:0]  i_Pair,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [7:0]  o_Read8,
  output logic [7:0]  o_Write8,
  output logic [5:0]  o_Read16,
  output logic [5:0]  o_Write16,
  output logic [7:0]  o_Bus8,
  output logic [15:0] o_Bus16,
  input  logic [7:0]  i_Bus8,
  input  logic [15:0] i_Bus16,
  output logic        o_Mem_Req,
  output logic        o_Mem_Write,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Data,
  input  logic [7:0]  i_Mem_Data,
  input  logic        i_Mem_Ack
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH_HI, S_MEM_HI, S_FETCH_LO, S_MEM_LO,
    S_WB_LO, S_WB_HI, S_WB_PC, S_DONE
  } state_t;

  state_t      r_State, w_State_n;
  logic        r_Op, r_Pc;
  logic [1:0]  r_Pair;
  logic [15:0] r_Sp, w_Sp_n;
  logic [7:0]  r_Data, w_Data_n, r_Lo;
  logic        r_Busy, r_Done, r_Mem_Req, r_Mem_Write;
  logic [7:0]  r_Bus8, r_Mem_Data;
  logic [15:0] r_Bus16, r_Mem_Addr;
  logic        w_Legal, w_Ack, w_Mem_n, w_Fetch_n, w_Wb_n;
  logic [2:0]  w_RegIdx;

`ifdef STACK_SEQ_PC_EN
  assign w_Legal = (i_Pair <= 3'd4);
`else
  assign w_Legal = ~i_Pair[2];
`endif

  assign w_Ack    = i_Mem_Ack & r_Mem_Req;
  // W,Z,B,C,... ordering: high register of pair p is 2p, low is 2p+1
  assign w_RegIdx = {r_Pair, (r_State == S_FETCH_LO) || (r_State == S_WB_LO)};

  always_comb begin
    w_State_n = r_State;
    w_Sp_n    = r_Sp;
    w_Data_n  = r_Data;
    case (r_State)
      S_IDLE:     if (i_Start && w_Legal) w_State_n = S_LOAD;
      S_LOAD: begin
        w_Sp_n    = i_Bus16;
        w_State_n = r_Op ? S_MEM_LO : S_FETCH_HI;
      end
      S_FETCH_HI: begin
        w_Sp_n    = r_Sp - 16'd1;
        w_Data_n  = r_Pc ? i_Bus16[15:8] : i_Bus8;
        w_State_n = S_MEM_HI;
      end
      S_FETCH_LO: begin
        w_Sp_n    = r_Sp - 16'd1;
        w_Data_n  = r_Pc ? i_Bus16[7:0] : i_Bus8;
        w_State_n = S_MEM_LO;
      end
      S_MEM_HI: if (w_Ack) begin
        if (r_Op) w_Data_n = i_Mem_Data;
        w_State_n = r_Op ? S_WB_HI : S_FETCH_LO;
      end
      S_MEM_LO: if (w_Ack) begin
        if (r_Op) w_Data_n = i_Mem_Data;
        w_State_n = r_Op ? S_WB_LO : S_DONE;
      end
      S_WB_LO: begin
        w_Sp_n    = r_Sp + 16'd1;
        w_State_n = S_MEM_HI;
      end
      S_WB_HI: begin
        w_Sp_n    = r_Sp + 16'd1;
        w_State_n = r_Pc ? S_WB_PC : S_DONE;
      end
      S_WB_PC:    w_State_n = S_DONE;
      S_DONE:     w_State_n = S_IDLE;
      default:    w_State_n = S_IDLE;
    endcase
  end

  // Strobes are gated by i_Enable so a frozen state never repeats a write.
  always_comb begin
    o_Read8   = '0;
    o_Write8  = '0;
    o_Read16  = '0;
    o_Write16 = '0;
    if (i_Enable) begin
      case (r_State)
        S_LOAD: o_Read16[4] = 1'b1;
        S_FETCH_HI, S_FETCH_LO: begin
          o_Write16[4] = 1'b1;
          if (r_Pc) o_Read16[5] = 1'b1;
          else      o_Read8[w_RegIdx] = 1'b1;
        end
        S_WB_LO, S_WB_HI: begin
          o_Write16[4] = 1'b1;
          if (!r_Pc) o_Write8[w_RegIdx] = 1'b1;
        end
        S_WB_PC: o_Write16[5] = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_Mem_n   = (w_State_n == S_MEM_HI)   || (w_State_n == S_MEM_LO);
  assign w_Fetch_n = (w_State_n == S_FETCH_HI) || (w_State_n == S_FETCH_LO);
  assign w_Wb_n    = (w_State_n == S_WB_HI)    || (w_State_n == S_WB_LO);

  // Registered outputs are computed from the state being entered.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= S_IDLE;
      r_Op        <= 1'b0;
      r_Pc        <= 1'b0;
      r_Pair      <= '0;
      r_Sp        <= '0;
      r_Data      <= '0;
      r_Lo        <= '0;
      r_Busy      <= 1'b0;
      r_Done      <= 1'b0;
      r_Mem_Req   <= 1'b0;
      r_Mem_Write <= 1'b0;
      r_Mem_Addr  <= '0;
      r_Mem_Data  <= '0;
      r_Bus8      <= '0;
      r_Bus16     <= '0;
    end else if (i_Enable) begin
      r_State <= w_State_n;
      r_Sp    <= w_Sp_n;
      r_Data  <= w_Data_n;
      if (r_State == S_IDLE && i_Start && w_Legal) begin
        r_Op   <= i_Op;
        r_Pair <= i_Pair[1:0];
`ifdef STACK_SEQ_PC_EN
        r_Pc   <= (i_Pair == 3'd4);
`else
        r_Pc   <= 1'b0;
`endif
      end
      if (r_State == S_WB_LO) r_Lo <= r_Data;
      r_Busy      <= (w_State_n != S_IDLE);
      r_Done      <= (w_State_n == S_DONE);
      r_Mem_Req   <= w_Mem_n;
      r_Mem_Write <= w_Mem_n & ~r_Op;
      r_Mem_Addr  <= w_Mem_n ? w_Sp_n : 16'd0;
      r_Mem_Data  <= (w_Mem_n && !r_Op) ? w_Data_n : 8'd0;
      r_Bus8      <= w_Wb_n ? w_Data_n : 8'd0;
      if (w_Fetch_n)                  r_Bus16 <= w_Sp_n - 16'd1;
      else if (w_Wb_n)                r_Bus16 <= w_Sp_n + 16'd1;
      else if (w_State_n == S_WB_PC)  r_Bus16 <= {w_Data_n, r_Lo};
      else                            r_Bus16 <= 16'd0;
    end
  end

  assign o_Busy      = r_Busy;
  assign o_Done      = r_Done;
  assign o_Bus8      = r_Bus8;
  assign o_Bus16     = r_Bus16;
  assign o_Mem_Req   = r_Mem_Req;
  assign o_Mem_Write = r_Mem_Write;
  assign o_Mem_Addr  = r_Mem_Addr;
  assign o_Mem_Data  = r_Mem_Data;
endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer with register-file and memory models and an access scoreboard.
module tb_stack_sequencer;
  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Enable, i_Start, i_Op;
  logic [2:0]  i_Pair;
  logic        o_Busy, o_Done, o_Mem_Req, o_Mem_Write, i_Mem_Ack;
  logic [7:0]  o_Read8, o_Write8, o_Bus8, i_Bus8, o_Mem_Data, i_Mem_Data;
  logic [5:0]  o_Read16, o_Write16;
  logic [15:0] o_Bus16, i_Bus16, o_Mem_Addr;

  always #5 i_Clk = ~i_Clk;

  stack_sequencer dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Start(i_Start),
    .i_Op(i_Op), .i_Pair(i_Pair), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Read8(o_Read8), .o_Write8(o_Write8), .o_Read16(o_Read16), .o_Write16(o_Write16),
    .o_Bus8(o_Bus8), .o_Bus16(o_Bus16), .i_Bus8(i_Bus8), .i_Bus16(i_Bus16),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Write(o_Mem_Write), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Data(o_Mem_Data), .i_Mem_Data(i_Mem_Data), .i_Mem_Ack(i_Mem_Ack)
  );

  // Register file model: W,Z,B,C,D,E,H,L plus SP and PC.
  logic [7:0]  rf8 [0:7];
  logic [15:0] sp_m, pc_m;
  logic        ld;
  logic [63:0] ld_rf;
  logic [15:0] ld_sp, ld_pc;

  always_comb begin
    i_Bus8 = 8'h00;
    for (int i = 0; i < 8; i++) if (o_Read8[i]) i_Bus8 = rf8[i];
    i_Bus16 = 16'h0000;
    for (int j = 0; j < 4; j++) if (o_Read16[j]) i_Bus16 = {rf8[2*j], rf8[2*j+1]};
    if (o_Read16[4]) i_Bus16 = sp_m;
    if (o_Read16[5]) i_Bus16 = pc_m;
  end

  always @(posedge i_Clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++) rf8[i] <= ld_rf[63-8*i -: 8];
      sp_m <= ld_sp;
      pc_m <= ld_pc;
    end else begin
      for (int i = 0; i < 8; i++) if (o_Write8[i]) rf8[i] <= o_Bus8;
      if (o_Write16[4]) sp_m <= o_Bus16;
      if (o_Write16[5]) pc_m <= o_Bus16;
    end
  end

  // Memory model with programmable ack delay; delay only counts enabled cycles.
  logic [7:0]  mem [0:65535];
  int          ack_dly, ack_cnt;
  logic [24:0] obs_log [0:63];
  logic [5:0]  obs_n;
  logic        p_req, p_acc;
  logic [24:0] p_sig;
  int          unstable;

  assign i_Mem_Ack  = o_Mem_Req && (ack_cnt >= ack_dly);
  assign i_Mem_Data = mem[o_Mem_Addr];

  initial begin
    obs_n = '0; ack_cnt = 0; unstable = 0; p_req = 1'b0; p_acc = 1'b0; p_sig = '0;
  end

  always @(posedge i_Clk) begin
    if (!o_Mem_Req) ack_cnt <= 0;
    else if (i_Enable && ack_cnt < ack_dly) ack_cnt <= ack_cnt + 1;
    if (i_Enable && o_Mem_Req && i_Mem_Ack) begin
      obs_log[obs_n] <= {o_Mem_Write, o_Mem_Addr, o_Mem_Write ? o_Mem_Data : i_Mem_Data};
      obs_n <= obs_n + 6'd1;
      if (o_Mem_Write) mem[o_Mem_Addr] <= o_Mem_Data;
    end
    if (o_Mem_Req && p_req && !p_acc && ({o_Mem_Write, o_Mem_Addr, o_Mem_Data} != p_sig))
      unstable <= unstable + 1;
    p_req <= o_Mem_Req;
    p_acc <= i_Enable && o_Mem_Req && i_Mem_Ack;
    p_sig <= {o_Mem_Write, o_Mem_Addr, o_Mem_Data};
  end

  logic [79:0] outs_vec;
  assign outs_vec = {o_Busy, o_Done, o_Read8, o_Write8, o_Read16, o_Write16, o_Bus8, o_Bus16,
                     o_Mem_Req, o_Mem_Write, o_Mem_Addr, o_Mem_Data};

  int          n_assert = 0, n_fail = 0;
  logic [24:0] exp_q [$];
  logic [5:0]  obs_rd;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_acc(input logic we, input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({we, a, d});
  endtask

  task automatic check_sb(input string tag);
    logic [24:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd != obs_n) begin
        chk(tag, 80'(obs_log[obs_rd]), 80'(e));
        obs_rd++;
      end else chk({tag, "_missing"}, '1, 80'(e));
    end
    chk({tag, "_extra"}, 80'(obs_n), 80'(obs_rd));
  endtask

  task automatic load_regs(input logic [63:0] r, input logic [15:0] s, input logic [15:0] p);
    ld_rf = r; ld_sp = s; ld_pc = p; ld = 1'b1;
    @(negedge i_Clk);
    ld = 1'b0;
  endtask

  // Start an op and count negedges until o_Done; optional disable window, busy-start, reset.
  task automatic run_op(input logic op, input logic [2:0] pair, input int exp_cyc,
                        input int dis_at, input int bst_at, input int rst_at, input string tag);
    int cyc;
    i_Op = op; i_Pair = pair; i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, 80'(o_Busy), 80'(1));
    while (!o_Done && cyc < 100) begin
      @(negedge i_Clk);
      cyc++;
      if (cyc == dis_at)     i_Enable = 1'b0;
      if (cyc == dis_at + 2) i_Enable = 1'b1;
      if (cyc == bst_at) begin i_Start = 1'b1; i_Op = 1'b1; i_Pair = 3'd3; end
      if (cyc == bst_at + 1) i_Start = 1'b0;
      if (cyc == rst_at) begin
        i_Reset = 1'b1;
        #1;
        chk({tag, "_rst_outs"}, outs_vec, 80'(0));
        return;
      end
    end
    chk({tag, "_cycles"}, 80'(cyc), 80'(exp_cyc));
    @(negedge i_Clk);
    chk({tag, "_idle"}, 80'({o_Done, o_Busy}), 80'(0));
  endtask

  task automatic try_ignored(input logic [2:0] pair, input string tag);
    i_Op = 1'b0; i_Pair = pair; i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    chk({tag, "_busy1"}, 80'(o_Busy), 80'(0));
    @(negedge i_Clk);
    chk({tag, "_busy2"}, 80'({o_Busy, o_Done}), 80'(0));
    check_sb(tag);
  endtask

  initial begin
    i_Reset = 1'b1; i_Enable = 1'b1; i_Start = 1'b0; i_Op = 1'b0; i_Pair = 3'd0;
    ld = 1'b0; ld_rf = '0; ld_sp = '0; ld_pc = '0; ack_dly = 0; obs_rd = '0;
    repeat (3) @(negedge i_Clk);
    chk("reset_outs", outs_vec, 80'(0));
    i_Reset = 1'b0;
    load_regs(64'h0000_1234_0000_ABCD, 16'hFFFE, 16'h0150);
    chk("after_reset_idle", outs_vec, 80'(0));

    exp_acc(1, 16'hFFFD, 8'h12); exp_acc(1, 16'hFFFC, 8'h34);
    run_op(0, 3'd1, 6, -10, -10, -1, "push_bc");
    check_sb("push_bc_mem");
    chk("push_bc_sp", 80'(sp_m), 80'(16'hFFFC));

    exp_acc(0, 16'hFFFC, 8'h34); exp_acc(0, 16'hFFFD, 8'h12);
    run_op(1, 3'd2, 6, -10, -10, -1, "pop_de");
    check_sb("pop_de_mem");
    chk("pop_de_val", 80'({rf8[4], rf8[5]}), 80'(16'h1234));
    chk("pop_de_sp", 80'(sp_m), 80'(16'hFFFE));

    load_regs(64'h0000_1234_1234_ABCD, 16'h0001, 16'h0150);
    exp_acc(1, 16'h0000, 8'hAB); exp_acc(1, 16'hFFFF, 8'hCD);
    run_op(0, 3'd3, 6, -10, -10, -1, "push_hl_wrap");
    check_sb("push_hl_wrap_mem");
    chk("push_hl_wrap_sp", 80'(sp_m), 80'(16'hFFFF));

    exp_acc(0, 16'hFFFF, 8'hCD); exp_acc(0, 16'h0000, 8'hAB);
    run_op(1, 3'd0, 6, -10, -10, -1, "pop_wz_wrap");
    check_sb("pop_wz_wrap_mem");
    chk("pop_wz_wrap_val", 80'({rf8[0], rf8[1]}), 80'(16'hABCD));
    chk("pop_wz_wrap_sp", 80'(sp_m), 80'(16'h0001));

    // Wait states on both accesses, a 2-cycle freeze inside MEM_HI, and a start while busy.
    load_regs(64'hABCD_1234_1234_ABCD, 16'h1000, 16'h0150);
    ack_dly = 3;
    exp_acc(1, 16'h0FFF, 8'h12); exp_acc(1, 16'h0FFE, 8'h34);
    run_op(0, 3'd1, 14, 4, 8, -1, "push_slow");
    check_sb("push_slow_mem");
    chk("push_slow_sp", 80'(sp_m), 80'(16'h0FFE));
    chk("push_slow_stable", 80'(unstable), 80'(0));
    ack_dly = 0;

    try_ignored(3'd5, "illegal5");
`ifdef STACK_SEQ_PC_EN
    load_regs(64'hABCD_1234_1234_ABCD, 16'hC000, 16'h0150);
    exp_acc(1, 16'hBFFF, 8'h01); exp_acc(1, 16'hBFFE, 8'h50);
    run_op(0, 3'd4, 6, -10, -10, -1, "push_pc");
    check_sb("push_pc_mem");
    chk("push_pc_sp", 80'(sp_m), 80'(16'hBFFE));
    load_regs(64'hABCD_1234_1234_ABCD, 16'hBFFE, 16'h0000);
    exp_acc(0, 16'hBFFE, 8'h50); exp_acc(0, 16'hBFFF, 8'h01);
    run_op(1, 3'd4, 7, -10, -10, -1, "pop_pc");
    check_sb("pop_pc_mem");
    chk("pop_pc_val", 80'(pc_m), 80'(16'h0150));
    chk("pop_pc_sp", 80'(sp_m), 80'(16'hC000));
`else
    try_ignored(3'd4, "pc_disabled");
`endif

    // Reset in MEM_LO: both FETCH states have already strobed SP, so it stays at base-2.
    load_regs(64'hABCD_1234_1234_ABCD, 16'h2000, 16'h0150);
    exp_acc(1, 16'h1FFF, 8'h12);
    run_op(0, 3'd1, 6, -10, -10, 5, "push_rst");
    check_sb("push_rst_mem");
    chk("push_rst_sp", 80'(sp_m), 80'(16'h1FFE));
    @(negedge i_Clk);
    i_Reset = 1'b0;
    exp_acc(1, 16'h1FFD, 8'h12); exp_acc(1, 16'h1FFC, 8'h34);
    run_op(0, 3'd2, 6, -10, -10, -1, "push_after_rst");
    check_sb("push_after_rst_mem");
    chk("push_after_rst_sp", 80'(sp_m), 80'(16'h1FFC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
